sparse_chunk_scheduler: RTL
===========================

# sparse_chunk_scheduler

Sequences the sparse-match priority encoder across a layer's worth of bitmap chunks. Accepts IFM/filter bitmap chunk pairs from the bitmap fetch unit through a valid/ready handshake with a one-entry prefetch buffer. Drives the encoder's `valid`/`chunk_start`/bitmap inputs, holds the encoder when the MAC array back-pressures, and forwards each match address tagged with its chunk index. Signals completion after the programmed number of chunks is exhausted.

## Interface
- `CNT_W`, default 8: width of the chunk count and chunk index.
- W: bitmap width, equal to `` `PREFIX_SUM_SIZE `` from Global_Include.vh. AW = `$clog2(W)`.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: asynchronous active-high reset.
- `start_i` in 1: starts a job. Ignored while `busy_o`=1.
- `num_chunks_i` in CNT_W: chunk count, sampled on an accepted `start_i`.
- `chunk_valid_i` / `chunk_ready_o`: in / out, 1 each. Fetch handshake.
- `ifm_bmp_i` / `filt_bmp_i`: in, W each. Chunk bitmaps.
- `enc_valid_o` out 1: to encoder `valid_i`.
- `enc_chunk_start_o` out 1: to encoder `chunk_start_i`.
- `enc_in1_o` / `enc_in2_o`: out, W each. To encoder `in1_i`/`in2_i`.
- `enc_match_i` in 1: encoder `valid_o`.
- `enc_addr_i` in AW: encoder `match_addr_o`.
- `enc_last_i` in 1: encoder `pri_enc_last_o`.
- `mac_ready_i` in 1: MAC array can take a match this cycle.
- `mac_valid_o` out 1: match valid to MAC.
- `mac_addr_o` out AW: match bit address.
- `mac_chunk_o` out CNT_W: index of the current chunk.
- `busy_o` out 1: job in progress.
- `done_o` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, FETCH, SCAN, DONE.
  - IDLE: on `start_i`, latch `num_chunks_i` and clear the chunk index.
    - Count 0 → DONE.
    - Otherwise → FETCH.
  - FETCH: wait for the current-chunk register to be filled, then → SCAN.
  - SCAN: scan the current chunk.
  - DONE: one cycle, `done_o`=1, then → IDLE.
- Buffering:
  - Two registers: current (cur) and prefetch (nxt), each W+W bits plus a valid flag.
  - `chunk_ready_o` = busy and (cur empty or nxt empty) and (accepted + in-flight chunks < `num_chunks`).
  - Never accept more than `num_chunks` chunks.
- Encoder drive:
  - `enc_in1_o`/`enc_in2_o` = cur bitmaps.
  - `enc_valid_o` = (state==SCAN) and `mac_ready_i`.
  - `enc_chunk_start_o` = SCAN and the `first` flag. `first` is set on chunk entry and cleared on the first cycle with `enc_valid_o`=1.
  - While `mac_ready_i`=0, the encoder holds its residual (valid low) and `chunk_start` stays pending.
- Match path (combinational):
  - `mac_valid_o` = `enc_match_i` & `enc_valid_o`.
  - `mac_addr_o` = `enc_addr_i`.
  - `mac_chunk_o` = chunk index.
- Chunk end: `enc_valid_o` & `enc_last_i`.
  - Chunk index increments.
  - Last chunk → DONE.
  - Else, if nxt is valid: move nxt → cur, stay in SCAN, set `first`.
  - Else → FETCH.
- Zero-match chunk (AND==0): consumes exactly one valid cycle with `chunk_start`=1. `enc_match_i`=0 and `enc_last_i`=1 in that cycle, so no `mac_valid_o` is produced.
- A fetch accept in the same cycle as chunk end loads cur directly when nxt is empty and cur is being freed. No cycle is lost.

## Timing
- Reset values: all outputs 0, FSM in IDLE, buffers empty, counters 0.
- Asynchronous reset mid-job aborts the job. No `done_o` is produced.
- `start_i` to first `chunk_ready_o`: 1 cycle.
- Chunk accepted in FETCH → SCAN the next cycle.
- K matches in a chunk take K valid cycles (minimum 1).
- Back-to-back chunks with nxt prefetched: zero bubble cycles.
- Last chunk end → `done_o` the next cycle. `busy_o` drops with `done_o`.
- `num_chunks`=0: `done_o` 1 cycle after `start_i`, and no fetch.
- The chunk index wraps only at 2^CNT_W, and never within a legal job.

## Structure
- Shared package `npu_sched_pkg` holds:
  - the state enum;
  - a `chunk_t` struct (ifm, filt, valid);
  - localparam AW derived from `` `PREFIX_SUM_SIZE ``.
- One natural sub-module: `chunk_prefetch_buf`, the two-entry cur/nxt buffer with the fetch handshake.
- The encoder is instantiated by the parent, not inside this block.

## Test plan
All scenarios run with `` `PREFIX_SUM_SIZE ``=16.
- **Single chunk:** num_chunks=1, ifm=16'h00F0, filt=16'h0FF0, `mac_ready_i`=1 → `mac_addr_o` 4,5,6,7 on consecutive cycles, all with `mac_chunk_o`=0. `done_o` follows 1 cycle after the last match.
- **Zero-match chunk:** num_chunks=2, chunk0 AND=0, chunk1 AND=16'h8001 → chunk0 uses 1 cycle with no `mac_valid_o`. Chunk1 gives addrs 0 and 15 with `mac_chunk_o`=1.
- **Back-pressure:** AND=16'h0003, `mac_ready_i` low for 3 cycles on the first SCAN cycle → `enc_chunk_start_o` stays high until ready. Output is addr 0 then addr 1, with no lost or duplicated match.
- **Prefetch:** 3 chunks, fetch always valid → no FETCH state between chunks, and `chunk_ready_o` deasserts after the 3rd accept.
- **num_chunks=0:** `done_o` pulses 1 cycle after start, `chunk_ready_o` never asserts, and `start_i` while busy is ignored.
- **Reset mid-scan:** assert `rst_i` asynchronously during chunk 1 → all outputs 0 immediately, no `done_o`. A new start runs normally afterwards.

Source files
------------

// File: rtl/npu_sched_pkg.sv
// Shared types for the sparse-match chunk scheduler.
// Holds the bitmap width (from PREFIX_SUM_SIZE), the match address width,
// the scheduler state enum and the buffered chunk payload.
`ifndef PREFIX_SUM_SIZE
`define PREFIX_SUM_SIZE 16
`endif

package npu_sched_pkg;

  localparam int unsigned W  = `PREFIX_SUM_SIZE;
  localparam int unsigned AW = $clog2(W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SCAN,
    ST_DONE
  } sched_state_e;

  typedef struct packed {
    logic [W-1:0] ifm;
    logic [W-1:0] filt;
    logic         valid;
  } chunk_t;

endpackage

// File: rtl/chunk_prefetch_buf.sv
// Two-entry (current + prefetch) bitmap chunk buffer with the fetch handshake.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   flush_i                 drop both entries (new job)
//   en_i                    fetch allowed (job busy and chunk quota left)
//   chunk_valid_i/ready_o   fetch handshake; accept_o = valid & ready
//   ifm_i, filt_i           incoming bitmaps
//   pop_i                   current chunk finished this cycle
//   cur_o                   current chunk (zero when empty)
//   nxt_valid_o             prefetch entry occupied
module chunk_prefetch_buf
  import npu_sched_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         en_i,
  input  logic         chunk_valid_i,
  output logic         chunk_ready_o,
  output logic         accept_o,
  input  logic [W-1:0] ifm_i,
  input  logic [W-1:0] filt_i,
  input  logic         pop_i,
  output chunk_t       cur_o,
  output logic         nxt_valid_o
);

  chunk_t cur_q;
  chunk_t nxt_q;
  chunk_t in_chunk;

  always_comb begin
    in_chunk       = '0;
    in_chunk.ifm   = ifm_i;
    in_chunk.filt  = filt_i;
    in_chunk.valid = 1'b1;
  end

  assign chunk_ready_o = en_i & (~cur_q.valid | ~nxt_q.valid);
  assign accept_o      = chunk_ready_o & chunk_valid_i;
  assign cur_o         = cur_q;
  assign nxt_valid_o   = nxt_q.valid;

  // On pop with an empty prefetch slot, an incoming chunk goes straight to cur.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_q <= '0;
      nxt_q <= '0;
    end else if (flush_i) begin
      cur_q <= '0;
      nxt_q <= '0;
    end else if (pop_i) begin
      if (nxt_q.valid) begin
        cur_q <= nxt_q;
        nxt_q <= accept_o ? in_chunk : '0;
      end else begin
        cur_q <= accept_o ? in_chunk : '0;
      end
    end else if (accept_o) begin
      if (!cur_q.valid) cur_q <= in_chunk;
      else              nxt_q <= in_chunk;
    end
  end

endmodule

// File: rtl/sparse_chunk_scheduler.sv
// Sequences the sparse-match priority encoder over a job of bitmap chunks,
// prefetching one chunk ahead and forwarding matches tagged with chunk index.
// Ports:
//   clk_i, rst_i                   clock, async active-high reset
//   start_i, num_chunks_i          job start and chunk count
//   chunk_valid_i/chunk_ready_o    fetch handshake, ifm_bmp_i/filt_bmp_i data
//   enc_*_o                        encoder drive (valid, chunk_start, in1, in2)
//   enc_match_i/addr_i/last_i      encoder results
//   mac_ready_i, mac_*_o           match stream to the MAC array
//   busy_o, done_o                 job status, one-cycle completion pulse
module sparse_chunk_scheduler
  import npu_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_chunks_i,
  input  logic             chunk_valid_i,
  output logic             chunk_ready_o,
  input  logic [W-1:0]     ifm_bmp_i,
  input  logic [W-1:0]     filt_bmp_i,
  output logic             enc_valid_o,
  output logic             enc_chunk_start_o,
  output logic [W-1:0]     enc_in1_o,
  output logic [W-1:0]     enc_in2_o,
  input  logic             enc_match_i,
  input  logic [AW-1:0]    enc_addr_i,
  input  logic             enc_last_i,
  input  logic             mac_ready_i,
  output logic             mac_valid_o,
  output logic [AW-1:0]    mac_addr_o,
  output logic [CNT_W-1:0] mac_chunk_o,
  output logic             busy_o,
  output logic             done_o
);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             first_q, first_d;

  chunk_t cur;
  logic   nxt_valid;
  logic   accept;
  logic   chunk_end;
  logic   last_chunk;
  logic   job_start;

  assign busy_o     = (state_q == ST_FETCH) | (state_q == ST_SCAN);
  assign done_o     = (state_q == ST_DONE);
  assign job_start  = (state_q == ST_IDLE) & start_i;

  assign enc_valid_o       = (state_q == ST_SCAN) & mac_ready_i;
  assign enc_chunk_start_o = (state_q == ST_SCAN) & first_q;
  assign enc_in1_o         = cur.ifm;
  assign enc_in2_o         = cur.filt;

  assign chunk_end  = enc_valid_o & enc_last_i;
  assign last_chunk = (idx_q == num_q - CNT_W'(1));

  // Address is forced to zero outside a valid match so idle/reset outputs are all-zero.
  assign mac_valid_o = enc_match_i & enc_valid_o;
  assign mac_addr_o  = mac_valid_o ? enc_addr_i : '0;
  assign mac_chunk_o = idx_q;

  chunk_prefetch_buf u_buf (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (job_start),
    .en_i          (busy_o & (acc_q < num_q)),
    .chunk_valid_i (chunk_valid_i),
    .chunk_ready_o (chunk_ready_o),
    .accept_o      (accept),
    .ifm_i         (ifm_bmp_i),
    .filt_i        (filt_bmp_i),
    .pop_i         (chunk_end),
    .cur_o         (cur),
    .nxt_valid_o   (nxt_valid)
  );

  // State and job counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      first_q <= first_d;
    end
  end

  // Next-state logic; a same-cycle accept keeps the scan going without a bubble.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    idx_d   = idx_q;
    acc_d   = accept ? acc_q + CNT_W'(1) : acc_q;
    first_d = first_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          num_d   = num_chunks_i;
          idx_d   = '0;
          acc_d   = '0;
          first_d = 1'b0;
          state_d = (num_chunks_i == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (cur.valid | accept) begin
          state_d = ST_SCAN;
          first_d = 1'b1;
        end
      end
      ST_SCAN: begin
        if (enc_valid_o) first_d = 1'b0;
        if (chunk_end) begin
          idx_d = idx_q + CNT_W'(1);
          if (last_chunk) begin
            state_d = ST_DONE;
          end else if (nxt_valid | accept) begin
            first_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
